// File: rtl/task_mapper_lb.sv
// Task mapper: collects a task-graph adjacency matrix, sums each task's outgoing
// communication volume and captures the root task. It then assigns every active
// task to the currently least-loaded processing element, root task first.
//
// state   | meaning
// --------+------------------------------------------------------------
// COLLECT | accepting matrix entries, accumulating volumes, root capture
// MAP     | scanning tasks, presenting (task, PE) pairs on map_* handshake
// FIN     | done pulse, clear per-application state, back to COLLECT
module task_mapper_lb #(
    parameter int NUM_V  = 4,
    parameter int NUM_PE = 2,
    parameter int W_W    = 32,
    parameter int VOL_W  = 32,
    localparam int IDX_W = (NUM_V > 1) ? $clog2(NUM_V) : 1,
    localparam int PE_W  = (NUM_PE > 1) ? $clog2(NUM_PE) : 1
) (
    input  logic             clk,
    input  logic             rst_b,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IDX_W-1:0] in_row,
    input  logic [IDX_W-1:0] in_col,
    input  logic [W_W-1:0]   in_weight,
    input  logic             app_end,
    output logic             root_valid,
    output logic [IDX_W-1:0] root_task,
    output logic             map_valid,
    input  logic             map_ready,
    output logic [IDX_W-1:0] map_task,
    output logic [PE_W-1:0]  map_pe,
    output logic             done,
    output logic             empty_app
);

    typedef enum logic [1:0] {S_COLLECT, S_MAP, S_FIN} state_t;

    // Scan step 0 is the root task, steps 1..NUM_V are indices 0..NUM_V-1.
    localparam int               STEP_W    = $clog2(NUM_V + 1);
    localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(NUM_V);
    localparam logic [IDX_W:0]    NUM_V_X   = (IDX_W + 1)'(NUM_V);
    localparam int               SUM_W     = ((VOL_W > W_W) ? VOL_W : W_W) + 1;
    localparam logic [VOL_W-1:0]  VOL_MAX   = '1;

    state_t             state_q, state_d;
    logic [VOL_W-1:0]   vol_q  [NUM_V];
    logic [VOL_W-1:0]   vol_d  [NUM_V];
    logic [VOL_W-1:0]   load_q [NUM_PE];
    logic [VOL_W-1:0]   load_d [NUM_PE];
    logic               root_valid_q, root_valid_d;
    logic [IDX_W-1:0]   root_task_q, root_task_d;
    logic [STEP_W-1:0]  step_q, step_d;

    logic               accept;
    logic               entry_ok;
    logic [IDX_W-1:0]   cur_idx;
    logic [VOL_W-1:0]   cur_vol;
    logic               cur_active;
    logic [PE_W-1:0]    best_pe;
    logic [VOL_W-1:0]   best_load;
    logic               handshake;
    logic               step_done;

    function automatic logic [VOL_W-1:0] sat_add_w(input logic [VOL_W-1:0] a,
                                                   input logic [W_W-1:0]   b);
        logic [SUM_W-1:0] s;
        s = SUM_W'(a) + SUM_W'(b);
        return (s > SUM_W'(VOL_MAX)) ? VOL_MAX : s[VOL_W-1:0];
    endfunction

    function automatic logic [VOL_W-1:0] sat_add_v(input logic [VOL_W-1:0] a,
                                                   input logic [VOL_W-1:0] b);
        logic [VOL_W:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[VOL_W] ? VOL_MAX : s[VOL_W-1:0];
    endfunction

    // Entry qualification, current scan task and least-loaded PE selection
    always_comb begin
        accept     = in_valid && in_ready;
        entry_ok   = accept && (in_weight != '0) && (in_row != in_col)
                     && ({1'b0, in_row} < NUM_V_X) && ({1'b0, in_col} < NUM_V_X);
        cur_idx    = (step_q == '0) ? root_task_q : IDX_W'(step_q - STEP_W'(1));
        cur_vol    = vol_q[cur_idx];
        // The root is revisited in ascending order and must be skipped there.
        cur_active = (cur_vol != '0) && ((step_q == '0) || (cur_idx != root_task_q));
        best_pe    = '0;
        best_load  = load_q[0];
        for (int p = 1; p < NUM_PE; p++) begin
            if (load_q[p] < best_load) begin
                best_load = load_q[p];
                best_pe   = PE_W'(p);
            end
        end
        handshake  = (state_q == S_MAP) && cur_active && map_ready;
        step_done  = (state_q == S_MAP) && (!cur_active || map_ready);
    end

    // State register
    always_ff @(posedge clk) begin
        if (!rst_b) state_q <= S_COLLECT;
        else        state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_COLLECT: if (app_end) state_d = (root_valid_q || entry_ok) ? S_MAP : S_FIN;
            S_MAP:     if (step_done && (step_q == LAST_STEP)) state_d = S_FIN;
            S_FIN:     state_d = S_COLLECT;
            default:   state_d = S_COLLECT;
        endcase
    end

    // Outputs decoded from state and scan position
    always_comb begin
        in_ready   = rst_b && (state_q == S_COLLECT);
        map_valid  = (state_q == S_MAP) && cur_active;
        map_task   = map_valid ? cur_idx : '0;
        map_pe     = map_valid ? best_pe : '0;
        done       = (state_q == S_FIN);
        empty_app  = (state_q == S_FIN) && !root_valid_q;
        root_valid = root_valid_q;
        root_task  = root_task_q;
    end

    // Next values for volumes, loads, root capture and scan step
    always_comb begin
        vol_d        = vol_q;
        load_d       = load_q;
        root_valid_d = root_valid_q;
        root_task_d  = root_task_q;
        step_d       = step_q;
        case (state_q)
            S_COLLECT: begin
                step_d = '0;
                if (entry_ok) begin
                    vol_d[in_row] = sat_add_w(vol_q[in_row], in_weight);
                    if (!root_valid_q) begin
                        root_valid_d = 1'b1;
                        root_task_d  = in_row;
                    end
                end
            end
            S_MAP: begin
                if (handshake) load_d[best_pe] = sat_add_v(load_q[best_pe], cur_vol);
                if (step_done) step_d = step_q + STEP_W'(1);
            end
            S_FIN: begin
                for (int i = 0; i < NUM_V; i++)  vol_d[i]  = '0;
                for (int p = 0; p < NUM_PE; p++) load_d[p] = '0;
                root_valid_d = 1'b0;
                step_d       = '0;
            end
            default: step_d = '0;
        endcase
    end

    // Datapath registers
    always_ff @(posedge clk) begin
        if (!rst_b) begin
            for (int i = 0; i < NUM_V; i++)  vol_q[i]  <= '0;
            for (int p = 0; p < NUM_PE; p++) load_q[p] <= '0;
            root_valid_q <= 1'b0;
            root_task_q  <= '0;
            step_q       <= '0;
        end else begin
            vol_q        <= vol_d;
            load_q       <= load_d;
            root_valid_q <= root_valid_d;
            root_task_q  <= root_task_d;
            step_q       <= step_d;
        end
    end

endmodule

// File: tb/tb_task_mapper_lb.sv
// Bench for task_mapper_lb: directed matrices, expected mappings queued by the
// stimulus side and consumed by an independent monitor.
`timescale 1ns/1ps
module tb_task_mapper_lb;

    logic        clk = 1'b0;
    logic        rst_b = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [1:0]  in_row = '0;
    logic [1:0]  in_col = '0;
    logic [31:0] in_weight = '0;
    logic        app_end = 1'b0;
    logic        root_valid;
    logic [1:0]  root_task;
    logic        map_valid;
    logic        map_ready = 1'b1;
    logic [1:0]  map_task;
    logic        map_pe;
    logic        done;
    logic        empty_app;

    task_mapper_lb #(.NUM_V(4), .NUM_PE(2), .W_W(32), .VOL_W(32)) dut (
        .clk(clk), .rst_b(rst_b),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_row(in_row), .in_col(in_col), .in_weight(in_weight),
        .app_end(app_end),
        .root_valid(root_valid), .root_task(root_task),
        .map_valid(map_valid), .map_ready(map_ready),
        .map_task(map_task), .map_pe(map_pe),
        .done(done), .empty_app(empty_app)
    );

    always #5 clk = ~clk;

    typedef struct packed {logic [1:0] r; logic [1:0] c; logic [31:0] w;} ent_t;
    typedef struct packed {logic [1:0] t; logic p;} map_t;
    typedef struct packed {logic empty; logic rv; logic [1:0] rt;} fin_t;

    ent_t ent_q[$];
    map_t exp_map[$];
    fin_t exp_fin[$];
    int   checks = 0;
    int   failures = 0;
    int   stall_task = -1;
    int   stall_left = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic pe(input logic [1:0] r, input logic [1:0] c, input logic [31:0] w);
        ent_t e;
        e.r = r; e.c = c; e.w = w;
        ent_q.push_back(e);
    endtask

    task automatic pm(input logic [1:0] t, input logic p);
        map_t m;
        m.t = t; m.p = p;
        exp_map.push_back(m);
    endtask

    task automatic pf(input logic empty, input logic rv, input logic [1:0] rt);
        fin_t f;
        f.empty = empty; f.rv = rv; f.rt = rt;
        exp_fin.push_back(f);
    endtask

    // Reference matrix: vol = {12, 11, 6, 7}, root 0.
    // Greedy: 0->PE0 (12), 1->PE1 (11), 2->PE1 (17), 3->PE0 (19).
    task automatic push_m1();
        pe(0, 1, 5); pe(0, 3, 7); pe(1, 0, 5); pe(1, 2, 6); pe(2, 1, 6); pe(3, 0, 7);
        pm(0, 0); pm(1, 1); pm(2, 1); pm(3, 0);
        pf(0, 1, 0);
    endtask

    // map_ready driver: stalls a chosen task for stall_left cycles
    initial begin
        forever begin
            @(posedge clk); #1;
            if (map_valid && stall_left > 0 && int'(map_task) == stall_task) begin
                map_ready = 1'b0;
                stall_left--;
            end else begin
                map_ready = 1'b1;
            end
        end
    end

    // Monitor: consumes expected mappings / completions on DUT events
    initial begin
        map_t       m;
        fin_t       f;
        logic       held;
        logic [1:0] ht;
        logic       hp;
        held = 1'b0; ht = '0; hp = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_b) begin
                held = 1'b0;
            end else begin
                if (held) begin
                    chk("hold_valid", map_valid, 1);
                    chk("hold_task", map_task, ht);
                    chk("hold_pe", map_pe, hp);
                end
                if (map_valid && map_ready) begin
                    if (exp_map.size() == 0) begin
                        checks++; failures++;
                        $display("FAIL unexpected_map task=%0d pe=%0d", map_task, map_pe);
                    end else begin
                        m = exp_map.pop_front();
                        chk("map_task", map_task, m.t);
                        chk("map_pe", map_pe, m.p);
                    end
                end
                held = map_valid && !map_ready;
                ht   = map_task;
                hp   = map_pe;
                if (done) begin
                    if (exp_fin.size() == 0) begin
                        checks++; failures++;
                        $display("FAIL unexpected_done empty_app=%0d", empty_app);
                    end else begin
                        f = exp_fin.pop_front();
                        chk("empty_app", empty_app, f.empty);
                        chk("root_valid_fin", root_valid, f.rv);
                        if (f.rv) chk("root_task_fin", root_task, f.rt);
                    end
                end else if (empty_app) begin
                    checks++; failures++;
                    $display("FAIL empty_without_done actual=1 expected=0");
                end
            end
        end
    end

    task automatic do_reset();
        rst_b = 1'b0;
        exp_map.delete(); exp_fin.delete(); ent_q.delete();
        stall_left = 0; stall_task = -1;
        in_valid = 1'b0; app_end = 1'b0;
        #1;
        chk("in_ready_in_reset", in_ready, 0);
        @(posedge clk); #1;
        rst_b = 1'b1;
        @(negedge clk);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_map_valid", map_valid, 0);
        chk("rst_map_task", map_task, 0);
        chk("rst_map_pe", map_pe, 0);
        chk("rst_done", done, 0);
        chk("rst_empty_app", empty_app, 0);
        chk("rst_root_valid", root_valid, 0);
        chk("rst_root_task", root_task, 0);
        @(posedge clk); #1;
    endtask

    task automatic send_app(input bit merge, input bit chk_root);
        int n;
        n = ent_q.size();
        for (int i = 0; i < n; i++) begin
            in_valid  = 1'b1;
            in_row    = ent_q[i].r;
            in_col    = ent_q[i].c;
            in_weight = ent_q[i].w;
            app_end   = merge && (i == n - 1);
            chk("in_ready_collect", in_ready, 1);
            @(posedge clk); #1;
            if (chk_root && i == 0) begin
                chk("root_valid_early", root_valid, 1);
                chk("root_task_early", root_task, ent_q[0].r);
            end
        end
        in_valid  = 1'b0;
        in_weight = '0;
        if (!merge) begin
            app_end = 1'b1;
            @(posedge clk); #1;
        end
        app_end = 1'b0;
        ent_q.delete();
    endtask

    task automatic wait_done(input int exp_n, input string name);
        bit got;
        int n;
        got = 1'b0; n = 0;
        for (int k = 1; k <= 100; k++) begin
            @(negedge clk);
            if (done) begin
                got = 1'b1; n = k;
                break;
            end
        end
        if (!got) begin
            checks++; failures++;
            $display("FAIL %s timeout waiting for done", name);
        end else begin
            chk(name, n, exp_n);
        end
        chk("exp_map_drained", exp_map.size(), 0);
        @(posedge clk); #1;
    endtask

    initial begin
        @(posedge clk); #1;
        do_reset();

        // Basic mapping, all map_ready high
        push_m1();
        send_app(0, 1);
        wait_done(6, "latency_basic");

        // Back-pressure on task 1 for three cycles
        push_m1();
        stall_task = 1; stall_left = 3;
        send_app(0, 0);
        wait_done(9, "latency_stall");

        // Only zero weights and a self-loop: empty application
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                pe(2'(r), 2'(c), (r == 2 && c == 2) ? 32'd9 : 32'd0);
        pf(1, 0, 0);
        send_app(0, 0);
        wait_done(1, "latency_empty");
        chk("root_valid_after_empty", root_valid, 0);

        // Saturation: vol[1] = sat(0xFFFFFFF0 + 0x20) = 0xFFFFFFFF, vol[0] = 20, vol[2] = 3.
        // 1->PE0, 0->PE1 (20), 2->PE1 (23); a wrapped vol[1]=0x10 would send task 2 to PE0.
        pe(1, 0, 32'hFFFF_FFF0); pe(1, 2, 32'h20); pe(0, 1, 32'd20); pe(2, 0, 32'd3);
        pm(1, 0); pm(0, 1); pm(2, 1);
        pf(0, 1, 1);
        send_app(0, 1);
        wait_done(6, "latency_sat");

        // Last entry together with app_end: task 3 must still be mapped
        push_m1();
        send_app(1, 0);
        wait_done(6, "latency_merge");

        // Same again, then reset in the middle of MAP
        push_m1();
        send_app(1, 0);
        @(negedge clk);
        chk("merge_map_valid", map_valid, 1);
        chk("merge_map_task", map_task, 0);
        @(posedge clk); #1;
        do_reset();

        push_m1();
        send_app(0, 1);
        wait_done(6, "latency_after_reset");

        // Back-to-back applications
        for (int a = 0; a < 500; a++) begin
            push_m1();
            send_app(0, 0);
            wait_done(6, "latency_b2b");
        end

        chk("exp_fin_drained", exp_fin.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout");
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

endmodule
